sblk_row_sched: RTL and testbench



---
 rtl/sblk_sched_pkg.sv | 20 ++
 rtl/sblk_sched_fifo.sv | 68 ++++++
 rtl/sblk_row_sched.sv | 159 +++++++++++++++
 tb/tb_sblk_row_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_sched_pkg.sv
// Shared definitions for the superblock row scheduler.
//   - Instruction field widths (TN/TM/TP/LN/LP) and the total instruction width.
//   - Scheduler FSM state encoding.
package sblk_sched_pkg;

    localparam int WID_TN   = 3;
    localparam int WID_TM   = 3;
    localparam int WID_TP   = 2;
    localparam int WID_LN   = 3;
    localparam int WID_LP   = 3;
    localparam int WID_INST = WID_TN + WID_TM + WID_TP + WID_LN + WID_LP;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sblk_sched_fifo.sv
// Small synchronous first-word-fall-through FIFO for scheduler commands.
// Ports:
//   clk, srst            clock and synchronous active-high reset
//   push, push_data      write request and data (ignored when full)
//   pop                  consume the head entry (ignored when empty)
//   full, empty          fill status
//   head_data            current head entry, valid whenever !empty
module sblk_sched_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Head is read combinationally so the controller sees it in the same
    // cycle it decides to pop; the storage is only a few registers deep.
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sblk_row_sched.sv
// Instruction scheduler for a row of superblocks.
// Buffers (instruction, row mask) commands and issues each instruction to
// every masked row once all of those rows report idle. A zero mask is a
// barrier that waits for the whole row to go idle without issuing.
// Ports:
//   clk_l, rst           clock and synchronous active-high reset
//   cmd_data/mask/vld    command input; cmd_rdy = FIFO not full
//   status_sblk          per-row busy flags (1 = busy)
//   inst_data            per-row instruction slots, row r at [r*WID_INST +: WID_INST]
//   inst_en              per-row one-cycle issue strobe
//   sched_busy           commands pending or FSM active
//   issue_cnt            count of non-barrier issues, wraps
module sblk_row_sched #(
    parameter int N_ROW      = 10,
    parameter int WID_INST   = sblk_sched_pkg::WID_INST,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_CYC   = 4,
    parameter int WID_CNT    = 16
) (
    input  logic                      clk_l,
    input  logic                      rst,
    input  logic [WID_INST-1:0]       cmd_data,
    input  logic [N_ROW-1:0]          cmd_mask,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic                      sched_busy,
    output logic [WID_CNT-1:0]        issue_cnt
);
    import sblk_sched_pkg::*;

    localparam int FW = WID_INST + N_ROW;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                fifo_push;
    logic [FW-1:0]       fifo_head;

    logic [N_ROW-1:0]    status_q_reg;
    sched_state_t        state_reg, state_next;
    logic [WID_INST-1:0] cur_data_reg, cur_data_next;
    logic [N_ROW-1:0]    cur_mask_reg, cur_mask_next;
    logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [N_ROW-1:0]    inst_en_reg;
    logic [WID_CNT-1:0]  issue_cnt_reg, issue_cnt_next;
    logic                issue_go;

    // Held low during reset so nothing is accepted into a FIFO being flushed.
    assign cmd_rdy    = !rst && !fifo_full;
    assign fifo_push  = cmd_vld && cmd_rdy;
    assign sched_busy = !fifo_empty || (state_reg != IDLE);
    assign inst_en    = inst_en_reg;
    assign issue_cnt  = issue_cnt_reg;

    sblk_sched_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_l),
        .srst      (rst),
        .push      (fifo_push),
        .push_data ({cmd_data, cmd_mask}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    always_comb begin
        state_next     = state_reg;
        cur_data_next  = cur_data_reg;
        cur_mask_next  = cur_mask_reg;
        hold_cnt_next  = hold_cnt_reg;
        issue_cnt_next = issue_cnt_reg;
        fifo_pop       = 1'b0;
        issue_go       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    cur_data_next = fifo_head[FW-1:N_ROW];
                    cur_mask_next = fifo_head[N_ROW-1:0];
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (cur_mask_reg != '0) begin
                    // Only rows in the mask gate the issue.
                    if ((status_q_reg & cur_mask_reg) == '0) begin
                        issue_go       = 1'b1;
                        issue_cnt_next = issue_cnt_reg + 1'b1;
                        state_next     = ISSUE;
                    end
                end else if (status_q_reg == '0) begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                hold_cnt_next = HOLD_LOAD;
                state_next    = HOLD;
            end
            HOLD: begin
                // Rows need time to raise busy after an issue, so status is
                // ignored for HOLD_CYC cycles before the next decision.
                if (hold_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The strobe and slot data are registered on the WAIT->ISSUE transition
    // so they are visible exactly while the FSM sits in ISSUE.
    always_ff @(posedge clk_l) begin
        if (rst) begin
            state_reg     <= IDLE;
            status_q_reg  <= '0;
            cur_data_reg  <= '0;
            cur_mask_reg  <= '0;
            hold_cnt_reg  <= '0;
            inst_en_reg   <= '0;
            issue_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            status_q_reg  <= status_sblk;
            cur_data_reg  <= cur_data_next;
            cur_mask_reg  <= cur_mask_next;
            hold_cnt_reg  <= hold_cnt_next;
            inst_en_reg   <= issue_go ? cur_mask_reg : '0;
            issue_cnt_reg <= issue_cnt_next;
        end
    end

    // Each slot only updates when its row is targeted; otherwise it keeps
    // the last instruction sent to that row.
    genvar gi;
    generate
        for (gi = 0; gi < N_ROW; gi++) begin : g_slot
            logic [WID_INST-1:0] slot_reg;
            always_ff @(posedge clk_l) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (issue_go && cur_mask_reg[gi]) begin
                    slot_reg <= cur_data_reg;
                end
            end
            assign inst_data[gi*WID_INST +: WID_INST] = slot_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sblk_row_sched.sv
// Self-checking bench for sblk_row_sched: directed stimulus pushes expected
// issues into a scoreboard queue; a negedge monitor pops and compares every
// time the DUT raises inst_en.
module tb_sblk_row_sched;

    localparam int N_ROW      = 10;
    localparam int WID_INST   = 14;
    localparam int FIFO_DEPTH = 4;
    localparam int HOLD_CYC   = 4;
    localparam int WID_CNT    = 16;

    logic                      clk_l = 1'b0;
    logic                      rst;
    logic [WID_INST-1:0]       cmd_data;
    logic [N_ROW-1:0]          cmd_mask;
    logic                      cmd_vld;
    logic                      cmd_rdy;
    logic [N_ROW-1:0]          status_sblk;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0]          inst_en;
    logic                      sched_busy;
    logic [WID_CNT-1:0]        issue_cnt;

    sblk_row_sched #(
        .N_ROW      (N_ROW),
        .WID_INST   (WID_INST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .HOLD_CYC   (HOLD_CYC),
        .WID_CNT    (WID_CNT)
    ) dut (
        .clk_l       (clk_l),
        .rst         (rst),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .status_sblk (status_sblk),
        .inst_data   (inst_data),
        .inst_en     (inst_en),
        .sched_busy  (sched_busy),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk_l = ~clk_l;

    int cyc = 0;
    always @(posedge clk_l) cyc <= cyc + 1;

    typedef struct {
        logic [N_ROW-1:0]    mask;
        logic [WID_INST-1:0] data;
        int                  when;
    } exp_t;

    exp_t                exp_q[$];
    logic [WID_INST-1:0] model_slot [N_ROW];
    logic [WID_CNT-1:0]  exp_cnt;
    int                  checks;
    int                  errors;
    bit                  mon_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_l);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_cnt = '0;
        for (int r = 0; r < N_ROW; r++) model_slot[r] = '0;
    endtask

    task automatic push(input logic [WID_INST-1:0] d, input logic [N_ROW-1:0] m, output int t);
        int n;
        n        = 0;
        cmd_data = d;
        cmd_mask = m;
        cmd_vld  = 1'b1;
        while (!cmd_rdy && n < 50) begin
            step();
            n++;
        end
        if (!cmd_rdy) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_rdy stayed 0, required 1 within 50 cycles");
        end
        t = cyc;
        step();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sched_busy || exp_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk(name, 64'(sched_busy || exp_q.size() != 0), 64'd0);
    endtask

    // Scoreboard monitor: every issue must match the next queued expectation.
    always @(negedge clk_l) begin : monitor
        exp_t e;
        if (mon_en && inst_en !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got inst_en 0x%0h at cycle %0d, required none", inst_en, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("issue_mask", 64'(inst_en), 64'(e.mask));
                chk("issue_cycle", 64'(cyc), 64'(e.when));
                for (int r = 0; r < N_ROW; r++) begin
                    if (e.mask[r]) model_slot[r] = e.data;
                end
                for (int r = 0; r < N_ROW; r++) begin
                    chk($sformatf("slot%0d", r), 64'(inst_data[r*WID_INST +: WID_INST]), 64'(model_slot[r]));
                end
                exp_cnt = exp_cnt + 1'b1;
                chk("issue_cnt", 64'(issue_cnt), 64'(exp_cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, tb, tc, f;
        int ta [5];

        checks      = 0;
        errors      = 0;
        mon_en      = 1'b0;
        rst         = 1'b1;
        cmd_vld     = 1'b0;
        cmd_data    = '0;
        cmd_mask    = '0;
        status_sblk = '0;
        clear_model();

        repeat (3) step();
        chk("rdy_in_reset", 64'(cmd_rdy), 64'd0);
        chk("inst_en_reset", 64'(inst_en), 64'd0);
        chk("issue_cnt_reset", 64'(issue_cnt), 64'd0);
        chk("inst_data_reset", 64'(inst_data != '0), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();
        chk("rdy_after_reset", 64'(cmd_rdy), 64'd1);
        chk("busy_after_reset", 64'(sched_busy), 64'd0);

        // 1: single issue, three cycles after the handshake.
        push(14'h1A5, 10'h005, t);
        exp_q.push_back('{10'h005, 14'h1A5, t + 3});
        wait_idle("t1_idle");
        chk("t1_cnt", 64'(issue_cnt), 64'd1);

        // 2: masked row busy stalls; issue two cycles after it falls.
        status_sblk = 10'h004;
        step();
        push(14'h0F0, 10'h004, t);
        repeat (10) step();
        chk("t2_busy_stalled", 64'(sched_busy), 64'd1);
        f           = cyc;
        status_sblk = '0;
        exp_q.push_back('{10'h004, 14'h0F0, f + 2});
        wait_idle("t2_idle");

        // 3: busy row outside the mask does not block.
        status_sblk = 10'h200;
        step();
        push(14'h2B3, 10'h001, t);
        exp_q.push_back('{10'h001, 14'h2B3, t + 3});
        wait_idle("t3_idle");
        status_sblk = '0;

        // Reset between tests clears counter and slots.
        rst = 1'b1;
        step();
        clear_model();
        chk("rst2_cnt", 64'(issue_cnt), 64'd0);
        chk("rst2_data", 64'(inst_data != '0), 64'd0);
        rst = 1'b0;
        step();

        // 4: barrier waits for row 9, which goes busy right after the first issue.
        push(14'h3C1, 10'h3FF, t0);
        exp_q.push_back('{10'h3FF, 14'h3C1, t0 + 3});
        push(14'h000, 10'h000, tb);
        push(14'h155, 10'h001, tc);
        goto(t0 + 4);
        status_sblk = 10'h200;
        goto(t0 + 15);
        chk("t4_busy_at_barrier", 64'(sched_busy), 64'd1);
        goto(t0 + 23);
        status_sblk = '0;
        exp_q.push_back('{10'h001, 14'h155, t0 + 27});
        wait_idle("t4_idle");
        chk("t4_cnt", 64'(issue_cnt), 64'd2);

        // 5: backpressure: 1 in WAIT + 4 in FIFO, then cmd_rdy drops.
        status_sblk = 10'h002;
        step();
        for (int i = 0; i < 5; i++) begin
            push(14'h101 + 14'(i), 10'h002, ta[i]);
        end
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t5_accept%0d_cycle", i), 64'(ta[i]), 64'(ta[0] + i));
        end
        cmd_data = 14'h106;
        cmd_mask = 10'h002;
        cmd_vld  = 1'b1;
        chk("t5_rdy_full", 64'(cmd_rdy), 64'd0);
        step();
        step();
        chk("t5_rdy_still_full", 64'(cmd_rdy), 64'd0);
        cmd_vld     = 1'b0;
        f           = cyc;
        status_sblk = '0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{10'h002, 14'h101 + 14'(i), f + 2 + 7 * i});
        end
        wait_idle("t5_idle");
        chk("t5_rdy_after", 64'(cmd_rdy), 64'd1);

        // 6: reset during ISSUE with three commands queued.
        status_sblk = 10'h008;
        step();
        push(14'h2AA, 10'h008, t);
        push(14'h2AB, 10'h008, t);
        push(14'h2AC, 10'h008, t);
        push(14'h2AD, 10'h008, t);
        f           = cyc;
        status_sblk = '0;
        exp_q.push_back('{10'h008, 14'h2AA, f + 2});
        goto(f + 2);
        rst = 1'b1;
        step();
        clear_model();
        chk("t6_inst_en", 64'(inst_en), 64'd0);
        chk("t6_cnt", 64'(issue_cnt), 64'd0);
        chk("t6_rdy_in_rst", 64'(cmd_rdy), 64'd0);
        rst = 1'b0;
        step();
        chk("t6_rdy", 64'(cmd_rdy), 64'd1);
        chk("t6_busy", 64'(sched_busy), 64'd0);
        repeat (20) step();
        chk("t6_no_stale_cnt", 64'(issue_cnt), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
